c64_bus_arbiter: RTL

Shares the single 64 KiB system RAM port between the 6502 core and the video fetch unit. Each CPU bus cycle is split into two clk slots: a video slot (phi1) and a CPU slot (phi2). The arbiter also runs a cycle-steal ("badline") sequencer that warns via `ba`, then stalls the core through a clock enable while video takes both slots. It sits between the core's `ab/do/di/we` pins, the video unit and the asynchronous-read RAM.

---
 rtl/c64_bus_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/c64_bus_arbiter.sv
// Splits each CPU bus cycle into a video slot (phase 0) and a CPU slot (phase 1)
// on the shared RAM port, and runs the ba-warned badline cycle-steal sequencer.
module c64_bus_arbiter #(
   parameter int BA_LEAD = 3,
   parameter int LEN_W   = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      cpu_ab,
   input  logic             cpu_we,
   input  logic [7:0]       cpu_do,
   output logic [7:0]       cpu_di,
   output logic             cpu_en,
   input  logic [15:0]      vid_ab,
   input  logic             vid_fetch,
   input  logic             vid_req,
   input  logic [LEN_W-1:0] vid_len,
   output logic             vid_ack,
   output logic [7:0]       vid_data,
   output logic             vid_valid,
   output logic             ba,
   output logic             phase,
   output logic [15:0]      mem_ab,
   output logic             mem_we,
   output logic [7:0]       mem_do,
   input  logic [7:0]       mem_di,
   output logic [1:0]       dbg_state_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WARN  = 2'd1,
      ST_STEAL = 2'd2
   } state_t;

   localparam logic [2:0]       WARN_ONE = 3'd1;
   localparam logic [2:0]       WARN_LD  = 3'(BA_LEAD);
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

   state_t           state_q, state_d;
   logic             phase_q, phase_d;
   logic [2:0]       warn_q, warn_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             ack_q, ack_d;
   logic [7:0]       hold_q, hold_d;
   logic [7:0]       vdata_q, vdata_d;
   logic             valid_q, valid_d;

   logic             steal;
   logic             cpu_slot;
   logic             vid_rd;

   assign steal    = (state_q == ST_STEAL);
   assign cpu_slot = phase_q & ~steal;
   assign vid_rd   = phase_q ? steal : vid_fetch;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         phase_q <= 1'b0;
         warn_q  <= '0;
         len_q   <= '0;
         ack_q   <= 1'b0;
         hold_q  <= '0;
         vdata_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         warn_q  <= warn_d;
         len_q   <= len_d;
         ack_q   <= ack_d;
         hold_q  <= hold_d;
         vdata_q <= vdata_d;
         valid_q <= valid_d;
      end
   end

   // Handshake: vid_req is a level held by video until vid_ack; vid_ack is a
   // single-clk pulse in the clk after the phase-1 edge that accepted the
   // request, and vid_len is captured on that same edge.
   always_comb begin
      state_d = state_q;
      warn_d  = warn_q;
      len_d   = len_q;
      ack_d   = 1'b0;
      phase_d = ~phase_q;
      if (phase_q) begin
         case (state_q)
            ST_IDLE: begin
               if (vid_req) begin
                  ack_d = 1'b1;
                  if (vid_len != '0) begin
                     len_d = vid_len;
                     if (BA_LEAD == 0) begin
                        state_d = ST_STEAL;
                     end else begin
                        state_d = ST_WARN;
                        warn_d  = WARN_LD;
                     end
                  end
               end
            end
            ST_WARN: begin
               // Counters stop at 1 so they can never wrap.
               if (warn_q <= WARN_ONE) begin
                  state_d = ST_STEAL;
               end else begin
                  warn_d = warn_q - WARN_ONE;
               end
            end
            ST_STEAL: begin
               if (len_q <= LEN_ONE) begin
                  state_d = ST_IDLE;
               end else begin
                  len_d = len_q - LEN_ONE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      hold_d  = cpu_slot ? mem_di : hold_q;
      vdata_d = vid_rd ? mem_di : vdata_q;
      valid_d = vid_rd;
   end

   // A stalled core keeps its write on the pins, so gating mem_we by slot
   // ownership alone defers the write to the first CPU slot after STEAL.
   assign mem_ab      = cpu_slot ? cpu_ab : vid_ab;
   assign mem_we      = cpu_slot & cpu_we;
   assign mem_do      = cpu_do;
   assign cpu_di      = cpu_slot ? mem_di : hold_q;
   assign cpu_en      = cpu_slot;
   assign ba          = (state_q == ST_IDLE);
   assign phase       = phase_q;
   assign vid_ack     = ack_q;
   assign vid_data    = vdata_q;
   assign vid_valid   = valid_q;
   assign dbg_state_o = state_q;

endmodule
